button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
- Input-side front end for the clock/calendar set logic. It turns raw active-low push-buttons (increase, decrease, change) into clean single-cycle event pulses that the time and date setting FSM consumes.
- Per button: 2-flop synchroniser, debounce, press/release edge pulses, and hold-then-auto-repeat event generation.
- Instantiated once at the top level, between the board pins and the counter core.

Parameters:
- N_BTN, 3, number of independent button channels.
- DEBOUNCE_CYC, 500_000, consecutive stable cycles needed to accept a level change (10 ms at 50 MHz).
- HOLD_CYC, 25_000_000, cycles from the press pulse to the first auto-repeat event (0.5 s).
- REPEAT_CYC, 12_500_000, cycles between subsequent auto-repeat events (0.25 s).
- CNT_W, 26, counter width; it must hold max(DEBOUNCE_CYC, HOLD_CYC, REPEAT_CYC).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  reset, asynchronous, active-low.
- btn_n  in  N_BTN  raw button pins; 0 = pressed. Asynchronous to clk.
- repeat_en  in  N_BTN  per-channel auto-repeat enable. Synchronous, quasi-static.
- level  out  N_BTN  debounced state; 1 = pressed.
- held  out  N_BTN  1 once a press has lasted HOLD_CYC cycles; cleared on release.
- press_pulse  out  N_BTN  1-cycle pulse when a press is accepted.
- release_pulse  out  N_BTN  1-cycle pulse when a release is accepted.
- event_pulse  out  N_BTN  1-cycle pulse on each press and on each auto-repeat tick. This is the increment/decrement strobe.

Behaviour:
- Reset: all outputs 0; synchronisers and debounced state = released (1); counters 0; FSM = BTN_IDLE. The reset assertion takes effect immediately, including in mid-operation.
- Synchroniser: 2 flops per channel, reset value 1.
- Debounce: the counter increments every cycle that the synchronised value differs from the stable value. It clears on any cycle where they are equal. When the count reaches DEBOUNCE_CYC-1, the stable value flips and the counter clears.
- Latency: level changes exactly 2+DEBOUNCE_CYC rising edges after the first edge that samples the new btn_n value, provided btn_n stays stable.
- FSM per channel:
  - BTN_IDLE: on accepted press, go to BTN_HOLD. press_pulse=1 and event_pulse=1 in the same cycle that level rises. Clear the timer.
  - BTN_HOLD: the timer counts. When timer == HOLD_CYC-1, go to BTN_REPEAT, set held=1, assert event_pulse if repeat_en, and clear the timer.
  - BTN_REPEAT: the timer counts. When timer == REPEAT_CYC-1, assert event_pulse if repeat_en and clear the timer.
  - Any state: on accepted release, go to BTN_IDLE. release_pulse=1 in the same cycle that level falls; held=0; timer cleared.
- Resulting timing: the first repeat event comes exactly HOLD_CYC cycles after the press pulse; later events come every REPEAT_CYC cycles.
- repeat_en is sampled only at timer terminal cycles. When it is 0, the pulse is suppressed but the timing continues.
- Simultaneous release and timer terminal in the same cycle: release wins. No event_pulse is generated.
- Pulses last exactly 1 cycle. event_pulse and release_pulse are never asserted together on one channel.
- Channels are fully independent. Simultaneous presses give simultaneous pulses with no arbitration.
- Button held through reset: after rst_n deasserts, the press is detected as a fresh press. press_pulse follows after 2+DEBOUNCE_CYC cycles.
- All counters saturate-free: each counter clears at its terminal value and never wraps.
- Elaboration check: fatal error if any *_CYC < 1 or any *_CYC > 2**CNT_W.

Decomposition:
- Package button_cond_pkg:
  - typedef enum btn_state_e {BTN_IDLE, BTN_HOLD, BTN_REPEAT}.
  - Default timing localparams DEF_DEBOUNCE_CYC, DEF_HOLD_CYC, DEF_REPEAT_CYC for 50 MHz.
- Sub-module button_channel: one synchroniser, one debouncer, the FSM and the timer. Same parameters, scalar ports.
- button_conditioner is a generate loop of N_BTN button_channel instances.

Test Plan (DEBOUNCE_CYC=4, HOLD_CYC=10, REPEAT_CYC=5, N_BTN=3):
- Bounce: btn_n[0] low 3 cycles, high 2, low 3, then high -> level, press_pulse and event_pulse stay 0 throughout.
- Clean press: btn_n[0] low from edge 0 -> at edge 6, level=1 with press_pulse=event_pulse=1 for one cycle. Release at edge 20 -> at edge 26, level=0 with release_pulse=1 for one cycle, held=0.
- Auto-repeat: repeat_en[1]=1, btn_n[1] held 40 cycles -> event_pulse at press+0, +10, +15, +20, +25, +30, +35. held=1 from +10.
- Repeat disabled: repeat_en[2]=0, held 30 cycles -> only the press event_pulse. held rises at +10; no further events.
- Reset mid-repeat: rst_n low during BTN_REPEAT -> all outputs 0 immediately. rst_n high with button still low -> press_pulse 6 cycles later.
- Collision and concurrency: ch0 and ch1 pressed on the same edge -> identical pulse timing on both. Arrange the release to be accepted on the +15 terminal -> release_pulse=1, event_pulse=0.

Source files
------------

// File: rtl/button_cond_pkg.sv
// Shared types and default 50 MHz timing for the push-button front end.
package button_cond_pkg;

  typedef enum logic [1:0] {
    BTN_IDLE,
    BTN_HOLD,
    BTN_REPEAT
  } btn_state_e;

  localparam int DEF_DEBOUNCE_CYC = 500_000;     // 10 ms
  localparam int DEF_HOLD_CYC     = 25_000_000;  // 0.5 s
  localparam int DEF_REPEAT_CYC   = 12_500_000;  // 0.25 s
  localparam int DEF_CNT_W        = 26;

endpackage

// File: rtl/button_channel.sv
// One button: 2-flop synchroniser, debouncer, and hold/auto-repeat FSM
// with registered, glitch-free outputs.
module button_channel
  import button_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int HOLD_CYC     = DEF_HOLD_CYC,
  parameter int REPEAT_CYC   = DEF_REPEAT_CYC,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  input  logic repeat_en,
  output logic level,
  output logic held,
  output logic press_pulse,
  output logic release_pulse,
  output logic event_pulse
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);

  logic             sync_q1, sync_q2;
  logic             stable_n;
  logic [CNT_W-1:0] deb_cnt;
  logic             pressed;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
    end else begin
      sync_q1 <= btn_n;
      sync_q2 <= sync_q1;
    end
  end

  // A level change is accepted only after DEBOUNCE_CYC consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_n <= 1'b1;
      deb_cnt  <= '0;
    end else if (sync_q2 == stable_n) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      stable_n <= sync_q2;
      deb_cnt  <= '0;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  assign pressed = ~stable_n;

  btn_state_e       state, state_d;
  logic [CNT_W-1:0] timer, timer_d;
  logic             hold_done, rep_done;
  logic             level_d, held_d, press_d, release_d, event_d;

  assign hold_done = (timer == HOLD_LAST);
  assign rep_done  = (timer == REP_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= BTN_IDLE;
      timer         <= '0;
      level         <= 1'b0;
      held          <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      event_pulse   <= 1'b0;
    end else begin
      state         <= state_d;
      timer         <= timer_d;
      level         <= level_d;
      held          <= held_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
      event_pulse   <= event_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state;
    timer_d = '0;
    if (!pressed) begin
      state_d = BTN_IDLE;
    end else begin
      case (state)
        BTN_IDLE:   state_d = BTN_HOLD;
        BTN_HOLD:   if (hold_done) state_d = BTN_REPEAT;
                    else           timer_d = timer + 1'b1;
        BTN_REPEAT: if (!rep_done) timer_d = timer + 1'b1;
        default:    state_d = BTN_IDLE;
      endcase
    end
  end

  // Release is checked first so it wins over a coincident timer terminal.
  always_comb begin
    level_d   = pressed;
    held_d    = held;
    press_d   = 1'b0;
    release_d = 1'b0;
    event_d   = 1'b0;
    if (!pressed) begin
      held_d    = 1'b0;
      release_d = (state != BTN_IDLE);
    end else begin
      case (state)
        BTN_IDLE: begin
          press_d = 1'b1;
          event_d = 1'b1;
        end
        BTN_HOLD: if (hold_done) begin
          held_d  = 1'b1;
          event_d = repeat_en;
        end
        BTN_REPEAT: if (rep_done) event_d = repeat_en;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Turns raw active-low buttons into debounced levels and single-cycle
// press/release/event strobes for the time and date setting logic.
module button_conditioner
  import button_cond_pkg::*;
#(
  parameter int N_BTN        = 3,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int HOLD_CYC     = DEF_HOLD_CYC,
  parameter int REPEAT_CYC   = DEF_REPEAT_CYC,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_n,
  input  logic [N_BTN-1:0] repeat_en,
  output logic [N_BTN-1:0] level,
  output logic [N_BTN-1:0] held,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] event_pulse
);

  localparam longint CNT_SPAN = 64'(1) << CNT_W;

  if (DEBOUNCE_CYC < 1 || HOLD_CYC < 1 || REPEAT_CYC < 1 ||
      longint'(DEBOUNCE_CYC) > CNT_SPAN || longint'(HOLD_CYC) > CNT_SPAN ||
      longint'(REPEAT_CYC) > CNT_SPAN) begin : g_bad_param
    $fatal(1, "button_conditioner: *_CYC must be in 1 .. 2**CNT_W");
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .HOLD_CYC     (HOLD_CYC),
      .REPEAT_CYC   (REPEAT_CYC),
      .CNT_W        (CNT_W)
    ) u_channel (
      .clk           (clk),
      .rst_n         (rst_n),
      .btn_n         (btn_n[i]),
      .repeat_en     (repeat_en[i]),
      .level         (level[i]),
      .held          (held[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .event_pulse   (event_pulse[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench: button waveforms are built as segments, expected pulses
// are derived from segment lengths and timing rules, and a monitor pops them.
module tb_button_conditioner;

  localparam int N    = 3;
  localparam int DEB  = 4;
  localparam int HOLD = 10;
  localparam int REP  = 5;

  typedef enum int {K_PRESS, K_HELD, K_EVENT, K_RELEASE} kind_e;
  typedef struct { int cyc; kind_e kind; } exp_t;
  typedef struct { bit val; int len; } seg_t;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] btn_n, repeat_en;
  logic [N-1:0] level, held, press_pulse, release_pulse, event_pulse;
  logic [N-1:0] held_prev;

  int   cyc     = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[N][$];
  seg_t sched[N][$];

  button_conditioner #(
    .N_BTN        (N),
    .DEBOUNCE_CYC (DEB),
    .HOLD_CYC     (HOLD),
    .REPEAT_CYC   (REP),
    .CNT_W        (26)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_n         (btn_n),
    .repeat_en     (repeat_en),
    .level         (level),
    .held          (held),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .event_pulse   (event_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic push(input int ch, input int c, input kind_e k);
    exp_t e;
    e.cyc  = c;
    e.kind = k;
    exp_q[ch].push_back(e);
  endtask

  task automatic add_seg(input int ch, input bit v, input int len);
    seg_t s;
    s.val = v;
    s.len = len;
    sched[ch].push_back(s);
  endtask

  task automatic clear_sched();
    for (int ch = 0; ch < N; ch++) sched[ch].delete();
  endtask

  // A differing run of at least DEB samples set at cycle t is accepted and
  // shows on the outputs at cycle t + 2 (sync) + DEB + 1 (output register).
  task automatic model_channel(input int ch, input int k0, input bit r);
    int t;
    bit stable;
    int acc_c[$];
    bit acc_v[$];
    int p, rr;
    t = k0;
    stable = 1'b1;
    for (int i = 0; i < sched[ch].size(); i++) begin
      if (sched[ch][i].val != stable && sched[ch][i].len >= DEB) begin
        acc_c.push_back(t + DEB + 3);
        acc_v.push_back(sched[ch][i].val);
        stable = sched[ch][i].val;
      end
      t += sched[ch][i].len;
    end
    for (int i = 0; i + 1 < acc_c.size(); i++) begin
      if (acc_v[i] == 1'b0) begin
        p  = acc_c[i];
        rr = acc_c[i+1];
        push(ch, p, K_PRESS);
        push(ch, p, K_EVENT);
        if (p + HOLD < rr) begin
          push(ch, p + HOLD, K_HELD);
          if (r) push(ch, p + HOLD, K_EVENT);
          for (int t2 = p + HOLD + REP; t2 < rr; t2 += REP)
            if (r) push(ch, t2, K_EVENT);
        end
        push(ch, rr, K_RELEASE);
      end
    end
  endtask

  task automatic run_phase(input logic [N-1:0] r_vec);
    int total[N];
    int pos[N];
    int left[N];
    int plen;
    int last;
    plen = 0;
    for (int ch = 0; ch < N; ch++) begin
      total[ch] = 0;
      for (int i = 0; i < sched[ch].size(); i++) total[ch] += sched[ch][i].len;
      if (total[ch] > plen) plen = total[ch];
    end
    plen += DEB + HOLD + 8;
    for (int ch = 0; ch < N; ch++) begin
      if (sched[ch].size() == 0 || sched[ch][sched[ch].size()-1].val == 1'b0)
        add_seg(ch, 1'b1, 0);
      last = sched[ch].size() - 1;
      sched[ch][last].len += plen - total[ch];
    end
    repeat_en = r_vec;
    for (int ch = 0; ch < N; ch++) begin
      model_channel(ch, cyc, r_vec[ch]);
      pos[ch]   = 0;
      left[ch]  = sched[ch][0].len;
      btn_n[ch] = sched[ch][0].val;
    end
    for (int c = 0; c < plen; c++) begin
      tick();
      for (int ch = 0; ch < N; ch++) begin
        left[ch]--;
        if (left[ch] == 0 && pos[ch] + 1 < sched[ch].size()) begin
          pos[ch]++;
          left[ch]  = sched[ch][pos[ch]].len;
          btn_n[ch] = sched[ch][pos[ch]].val;
        end
      end
    end
    for (int ch = 0; ch < N; ch++)
      check($sformatf("pending_expectations_ch%0d", ch), exp_q[ch].size(), 0);
    clear_sched();
  endtask

  task automatic sb_pop(input int ch, input kind_e k);
    exp_t e;
    if (exp_q[ch].size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_pulse_ch%0d: got kind %0d at cycle %0d, expected none",
               ch, k, cyc);
    end else begin
      e = exp_q[ch].pop_front();
      check($sformatf("pulse_kind_ch%0d", ch), k, e.kind);
      check($sformatf("pulse_cycle_ch%0d", ch), cyc, e.cyc);
    end
  endtask

  initial held_prev = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      for (int ch = 0; ch < N; ch++) begin
        if (press_pulse[ch]) begin
          sb_pop(ch, K_PRESS);
          check($sformatf("level_at_press_ch%0d", ch), level[ch], 1);
        end
        if (held[ch] && !held_prev[ch]) sb_pop(ch, K_HELD);
        if (event_pulse[ch]) sb_pop(ch, K_EVENT);
        if (release_pulse[ch]) begin
          sb_pop(ch, K_RELEASE);
          check($sformatf("level_at_release_ch%0d", ch), level[ch], 0);
          check($sformatf("held_at_release_ch%0d", ch), held[ch], 0);
        end
      end
    end
    held_prev <= held;
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_level"}, int'(level), 0);
    check({tag, "_held"}, int'(held), 0);
    check({tag, "_press"}, int'(press_pulse), 0);
    check({tag, "_release"}, int'(release_pulse), 0);
    check({tag, "_event"}, int'(event_pulse), 0);
  endtask

  initial begin
    int k;
    rst_n     = 1'b0;
    btn_n     = '1;
    repeat_en = '0;
    repeat (3) tick();
    check_all_zero("reset");
    rst_n = 1'b1;

    // Bounce then a clean press/release on ch0.
    clear_sched();
    add_seg(0, 1'b0, 3); add_seg(0, 1'b1, 2); add_seg(0, 1'b0, 3); add_seg(0, 1'b1, 20);
    add_seg(0, 1'b0, 20); add_seg(0, 1'b1, 30);
    run_phase(3'b000);

    // Auto-repeat on ch1, repeat disabled on ch2.
    add_seg(1, 1'b0, 40); add_seg(1, 1'b1, 10);
    add_seg(2, 1'b0, 30); add_seg(2, 1'b1, 10);
    run_phase(3'b010);

    // Concurrent press on ch0/ch1; release accepted on the +15 repeat terminal.
    add_seg(0, 1'b0, 15); add_seg(0, 1'b1, 10);
    add_seg(1, 1'b0, 15); add_seg(1, 1'b1, 10);
    run_phase(3'b011);

    // Reset in the middle of auto-repeat, button kept pressed through it.
    repeat_en = 3'b010;
    btn_n     = 3'b101;
    k = cyc;
    push(1, k + 7, K_PRESS);  push(1, k + 7, K_EVENT);
    push(1, k + 17, K_HELD);  push(1, k + 17, K_EVENT);
    push(1, k + 22, K_EVENT);
    repeat (24) tick();
    check("pre_reset_consumed", exp_q[1].size(), 0);
    check("pre_reset_held", held[1], 1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("mid_reset");
    for (int ch = 0; ch < N; ch++) exp_q[ch].delete();
    repeat (2) tick();
    rst_n = 1'b1;
    add_seg(1, 1'b0, 20); add_seg(1, 1'b1, 10);
    run_phase(3'b010);

    // Randomised waveforms with bounces on both edges.
    for (int ph = 0; ph < 12; ph++) begin
      for (int ch = 0; ch < N; ch++) begin
        int np;
        np = $urandom_range(1, 4);
        if ($urandom_range(0, 1) == 1) add_seg(ch, 1'b1, $urandom_range(1, 8));
        for (int i = 0; i < np; i++) begin
          add_seg(ch, 1'b0, ($urandom_range(0, 2) == 0) ? $urandom_range(1, DEB)
                                                        : $urandom_range(DEB, 45));
          add_seg(ch, 1'b1, $urandom_range(1, DEB + 3));
        end
      end
      run_phase(N'($urandom_range(0, 7)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
